// File: rtl/iter_shifter.sv
// Iterative multi-cycle shifter: up to STEP bits per cycle through an IDLE/SHIFT/DONE FSM.
// Define ITER_SHIFTER_ROTATE_EN to enable ROL/ROR (ops 3/4); otherwise they behave as illegal ops.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shiftamt,
    input  logic [2:0]       op,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] y
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // One extra bit so STEP and WIDTH themselves are representable as shift amounts.
    localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [2:0]       opr_q, opr_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SHW:0]     s_amt;
    logic             op_legal;

    always_comb begin
        op_legal = (opr_q == OP_SLL) || (opr_q == OP_SRL) || (opr_q == OP_SRA);
`ifdef ITER_SHIFTER_ROTATE_EN
        op_legal = op_legal || (opr_q == OP_ROL) || (opr_q == OP_ROR);
`endif
        s_amt = ({1'b0, rem_q} > STEP_W) ? STEP_W : {1'b0, rem_q};
    end

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        opr_d   = opr_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = data;
                    rem_d   = shiftamt;
                    opr_d   = op;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!op_legal) begin
                    // Illegal ops finish in a single cycle with a zero result.
                    work_d = '0;
                    rem_d  = '0;
                end else begin
                    case (opr_q)
                        OP_SLL:  work_d = work_q << s_amt;
                        OP_SRL:  work_d = work_q >> s_amt;
                        OP_SRA:  work_d = WIDTH'($signed(work_q) >>> s_amt);
`ifdef ITER_SHIFTER_ROTATE_EN
                        OP_ROL:  work_d = (work_q << s_amt) | (work_q >> (WIDTH_W - s_amt));
                        OP_ROR:  work_d = (work_q >> s_amt) | (work_q << (WIDTH_W - s_amt));
`endif
                        default: work_d = '0;
                    endcase
                    rem_d = rem_q - s_amt[SHW-1:0];
                end
                if (rem_d == '0) begin
                    state_d = S_DONE;
                    y_d     = work_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            opr_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            opr_q   <= opr_d;
            y_q     <= y_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign valid = (state_q == S_DONE);
    assign y     = y_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=32, STEP=4): cycle-level behavioural model plus directed cases.
// Honours ITER_SHIFTER_ROTATE_EN the same way as the design.
module tb_iter_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int STEP  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shiftamt;
    logic [2:0]       op;
    logic             ready, busy, valid;
    logic [WIDTH-1:0] y;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    iter_shifter #(.WIDTH(WIDTH), .SHW(SHW), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .shiftamt(shiftamt), .op(op),
        .ready(ready), .busy(busy), .valid(valid), .y(y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit ref_legal(input logic [2:0] o);
`ifdef ITER_SHIFTER_ROTATE_EN
        return o <= 3'd4;
`else
        return o <= 3'd2;
`endif
    endfunction

    function automatic logic [31:0] ref_y(input logic [31:0] d, input int a, input logic [2:0] o);
        logic [63:0] dd;
        dd = {d, d};
        if (!ref_legal(o)) return 32'h0;
        case (o)
            3'd0:    return d << a;
            3'd1:    return d >> a;
            3'd2:    return 32'($signed(d) >>> a);
            3'd3:    begin dd = dd << a; return dd[63:32]; end
            3'd4:    begin dd = dd >> a; return dd[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_k(input int a, input logic [2:0] o);
        if (!ref_legal(o) || a == 0) return 1;
        return (a + STEP - 1) / STEP;
    endfunction

    // Model: a request occupies K SHIFT cycles plus one DONE cycle; m_cnt counts cycles left.
    int          m_cnt = 0;
    logic [31:0] m_y   = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_y   = '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  = ref_k(int'(shiftamt), op) + 1;
                m_pend = ref_y(data, int'(shiftamt), op);
            end
        end else begin
            m_cnt--;
            if (m_cnt == 1) m_y = m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready", 64'(ready), 64'(m_cnt == 0));
            check("cyc_busy",  64'(busy),  64'(m_cnt > 0));
            check("cyc_valid", 64'(valid), 64'(m_cnt == 1));
            check("cyc_y",     64'(y),     64'(m_y));
        end
    end

    // Issue one request, scramble inputs while busy, optionally inject a second start at SHIFT cycle inject_at.
    task automatic run_case(input string name, input logic [31:0] d, input logic [4:0] a, input logic [2:0] o,
                            input logic [31:0] ey, input int ek, input int inject_at);
        int edges;
        bit seen;
        @(negedge clk);
        check({name, "_ready_at_issue"}, 64'(ready), 64'd1);
        data = d; shiftamt = a; op = o; start = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(negedge clk);
            edges++;
            if (valid) begin
                seen = 1'b1;
                check({name, "_y"}, 64'(y), 64'(ey));
                check({name, "_latency"}, 64'(edges), 64'(ek + 1));
            end
            start    = 1'($urandom_range(0, 1));
            data     = $urandom;
            shiftamt = 5'($urandom);
            op       = 3'($urandom);
            if (edges == inject_at) begin
                start = 1'b1;
                data  = 32'hFFFF_FFFF;
            end
        end
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data = '0; shiftamt = '0; op = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_busy",  64'(busy),  64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_y",     64'(y),     64'd0);
        // Reset must override start.
        start = 1'b1; data = 32'h1234_5678; shiftamt = 5'd3;
        @(negedge clk);
        check("reset_over_start_ready", 64'(ready), 64'd1);
        rst = 1'b0; start = 1'b0;
        chk_en = 1'b1;

        // Pin the model with hand-computed values.
        check("model_sll",  64'(ref_y(32'h1, 5, 3'd0)), 64'h20);
        check("model_k5",   64'(ref_k(5, 3'd0)), 64'd2);
        check("model_sra",  64'(ref_y(32'h8000_0000, 31, 3'd2)), 64'hFFFF_FFFF);
        check("model_k31",  64'(ref_k(31, 3'd2)), 64'd8);
        check("model_srl",  64'(ref_y(32'h8000_0000, 31, 3'd1)), 64'h1);
        check("model_rol",  64'(ref_y(32'h8000_0001, 1, 3'd3)),
`ifdef ITER_SHIFTER_ROTATE_EN
              64'h3);
`else
              64'h0);
`endif

        run_case("sll5",   32'h0000_0001, 5'd5,  3'd0, 32'h0000_0020, 2, 0);
        run_case("sra31",  32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, 8, 0);
        run_case("srl31",  32'h8000_0000, 5'd31, 3'd1, 32'h0000_0001, 8, 0);
`ifdef ITER_SHIFTER_ROTATE_EN
        run_case("ror4",   32'h0000_00F1, 5'd4,  3'd4, 32'h1000_000F, 1, 0);
        run_case("rol9",   32'hF000_0001, 5'd9,  3'd3, 32'h0000_03E0, 3, 0);
`else
        run_case("ror4",   32'h0000_00F1, 5'd4,  3'd4, 32'h0000_0000, 1, 0);
        run_case("rol9",   32'hF000_0001, 5'd9,  3'd3, 32'h0000_0000, 1, 0);
`endif
        run_case("op7",    32'h1234_5678, 5'd17, 3'd7, 32'h0000_0000, 1, 0);
        run_case("zero0",  32'hDEAD_BEEF, 5'd0,  3'd0, 32'hDEAD_BEEF, 1, 0);
        run_case("zero1",  32'hDEAD_BEEF, 5'd0,  3'd0, 32'hDEAD_BEEF, 1, 0);
        run_case("inject", 32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 8, 3);
        run_case("step4",  32'hF0F0_F0F0, 5'd4,  3'd1, 32'h0F0F_0F0F, 1, 0);

        // Reset on the 2nd SHIFT cycle of SRL by 20 aborts the request.
        @(negedge clk);
        data = 32'hCAFE_F00D; shiftamt = 5'd20; op = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_y",     64'(y),     64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        repeat (8) begin
            @(negedge clk);
            check("abort_no_valid", 64'(valid), 64'd0);
        end

        for (int i = 0; i < 200; i++) begin
            logic [31:0] d;
            logic [4:0]  a;
            logic [2:0]  o;
            d = $urandom;
            a = 5'($urandom);
            o = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            run_case("rand", d, a, o, ref_y(d, int'(a), o), ref_k(int'(a), o),
                     int'($urandom_range(0, 8)));
        end

        start = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
